ram_req_ctrl: RTL and testbench

Request controller directly upstream of the 32×32 dual-port RAM. It accepts write and read requests over valid/ready handshakes and buffers writes in a small posted-write queue. The queue drains into the RAM write port (`write_enable`/`write_address`/`data_in`), and reads are issued on the RAM read port (`read_enable`/`read_address`/`data_out`). A read that hits a buffered write is forwarded from the queue, and all read responses return in order at a fixed latency.

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_wb_fifo.sv | 65 ++++++
 rtl/ram_req_ctrl.sv | 120 ++++++++++++
 tb/tb_ram_req_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, read latency and write-request type for the RAM request controller
package ram_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/ram_wb_fifo.sv
// rtl/ram_wb_fifo.sv - posted-write queue; entries are exposed oldest-first for the read compare
module ram_wb_fifo
    import ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  wr_req_t               i_push_req,
    input  logic                  i_pop,
    output wr_req_t               o_head,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full,
    output logic [DEPTH-1:0]      o_ent_valid,
    output wr_req_t [DEPTH-1:0]   o_ent
);
    localparam int PTR_W = $clog2(DEPTH);

    wr_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Index 0 is the head, so a higher index is always a younger entry.
    always_comb begin
        o_ent       = '0;
        o_ent_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_ent[k]       = r_mem[r_rd_ptr + PTR_W'(k)];
            o_ent_valid[k] = CNT_W'(k) < r_count;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - write/read request controller in front of the dual-port RAM
module ram_req_ctrl #(
    parameter int DATA_W   = ram_pkg::DATA_W,
    parameter int ADDR_W   = ram_pkg::ADDR_W,
    parameter int WB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_fwd,
    input  logic                          drain_hold,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
    output logic                          write_enable,
    output logic [ADDR_W-1:0]             write_address,
    output logic [DATA_W-1:0]             data_in,
    output logic                          read_enable,
    output logic [ADDR_W-1:0]             read_address,
    input  logic [DATA_W-1:0]             data_out
);
    import ram_pkg::*;

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic [CNT_W-1:0]          w_count;
    logic                      w_full;
    wr_req_t                   w_head;
    logic [WB_DEPTH-1:0]       w_ent_valid;
    wr_req_t [WB_DEPTH-1:0]    w_ent;
    logic                      w_wr_fire;
    logic                      w_rd_fire;
    logic                      w_pop;
    logic                      w_hit;
    logic [DATA_W-1:0]         w_hit_data;

    wr_req_t                   r_wr;
    logic                      r_we;
    logic                      r_re;
    logic [ADDR_W-1:0]         r_raddr;
    logic [RD_LAT-1:0]         r_vld_pipe;
    logic [RD_LAT-1:0]         r_fwd_pipe;
    logic [DATA_W-1:0]         r_d1;
    logic [DATA_W-1:0]         r_d2;
    logic [DATA_W-1:0]         r_rsp_data;

    assign w_wr_fire = wr_valid && !w_full && !rst;
    assign w_rd_fire = rd_valid && !rst;
    assign w_pop     = (w_count != '0) && !drain_hold && !rst;

    ram_wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_wr_fire),
        .i_push_req  ('{addr: wr_addr, data: wr_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_ent_valid (w_ent_valid),
        .o_ent       (w_ent)
    );

    // Later matches overwrite earlier ones, leaving the youngest buffered write.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (w_ent_valid[k] && (w_ent[k].addr == rd_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = w_ent[k].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_raddr    <= '0;
            r_vld_pipe <= '0;
            r_fwd_pipe <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_rsp_data <= '0;
        end else begin
            r_we       <= w_pop;
            r_wr       <= w_head;
            r_re       <= w_rd_fire && !w_hit;
            r_raddr    <= rd_addr;
            r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], w_rd_fire};
            r_fwd_pipe <= {r_fwd_pipe[RD_LAT-2:0], w_rd_fire && w_hit};
            r_d1       <= w_hit_data;
            r_d2       <= r_d1;
            // Stage 2 of a miss lines up with the RAM's registered read data.
            r_rsp_data <= r_fwd_pipe[1] ? r_d2 : data_out;
        end
    end

    assign wr_ready      = !rst && !w_full;
    assign rd_ready      = !rst;
    assign wb_count      = rst ? '0 : w_count;
    assign write_enable  = r_we && !rst;
    assign write_address = rst ? '0 : r_wr.addr;
    assign data_in       = rst ? '0 : r_wr.data;
    assign read_enable   = r_re && !rst;
    assign read_address  = rst ? '0 : r_raddr;
    assign rsp_valid     = r_vld_pipe[RD_LAT-1] && !rst;
    assign rsp_fwd       = r_fwd_pipe[RD_LAT-1] && !rst;
    assign rsp_data      = rst ? '0 : r_rsp_data;
endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - scoreboard bench for ram_req_ctrl with a queue-level reference model
module tb_ram_req_ctrl;
    localparam int WB_DEPTH = 4;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fwd;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fwd;
    logic        drain_hold;
    logic [2:0]  wb_count;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] data_in;
    logic        read_enable;
    logic [4:0]  read_address;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] ram [32];
    logic [31:0] cm  [32];
    ev_t mq[$];
    ev_t exp_wr[$];
    ev_t exp_rd[$];
    ev_t exp_rsp[$];
    logic pend_v = 1'b0;
    ev_t  pend;

    ram_req_ctrl #(.DATA_W(32), .ADDR_W(5), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fwd(rsp_fwd),
        .drain_hold(drain_hold), .wb_count(wb_count),
        .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
        .read_enable(read_enable), .read_address(read_address), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no matching expectation (cycle %0d)", name, cyc);
    endtask

    // Environment RAM: registered read, read data valid the cycle after read_enable.
    always @(posedge clk) begin
        if (write_enable) ram[write_address] <= data_in;
        if (read_enable) data_out <= ram[read_address];
    end

    // Reference model: a plain FIFO of posted writes plus the committed memory image.
    always @(posedge clk) begin
        bit          hit;
        bit          can_push;
        logic [31:0] d;
        if (rst) begin
            mq.delete();
            exp_wr.delete();
            exp_rd.delete();
            exp_rsp.delete();
            pend_v = 1'b0;
        end else begin
            can_push = mq.size() < WB_DEPTH;
            if (pend_v) cm[pend.addr] = pend.data;
            pend_v = 1'b0;
            if (rd_valid) begin
                hit = 1'b0;
                d   = cm[rd_addr];
                foreach (mq[i]) if (mq[i].addr == rd_addr) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
                exp_rsp.push_back('{due: cyc + 3, addr: rd_addr, data: d, fwd: hit});
                if (!hit) exp_rd.push_back('{due: cyc + 1, addr: rd_addr, data: 32'h0, fwd: 1'b0});
            end
            if (mq.size() > 0 && !drain_hold) begin
                pend     = mq.pop_front();
                pend.due = cyc + 1;
                pend_v   = 1'b1;
                exp_wr.push_back(pend);
            end
            if (wr_valid && can_push)
                mq.push_back('{due: 0, addr: wr_addr, data: wr_data, fwd: 1'b0});
        end
        cyc++;
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            chk("reset_outputs", {wr_ready, rd_ready, rsp_valid, rsp_fwd, rsp_data, wb_count,
                write_enable, write_address, data_in, read_enable, read_address}, 128'h0);
        end else begin
            chk("wr_ready", wr_ready, mq.size() < WB_DEPTH);
            chk("rd_ready", rd_ready, 1'b1);
            chk("wb_count", wb_count, mq.size());
            if (write_enable) begin
                if (exp_wr.size() == 0) miss("write_unexpected");
                else begin
                    e = exp_wr.pop_front();
                    chk("write_cycle", cyc, e.due);
                    chk("write_address", write_address, e.addr);
                    chk("data_in", data_in, e.data);
                end
            end else if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
                miss("write_missing");
                void'(exp_wr.pop_front());
            end
            if (read_enable) begin
                if (exp_rd.size() == 0) miss("read_enable_unexpected");
                else begin
                    e = exp_rd.pop_front();
                    chk("read_cycle", cyc, e.due);
                    chk("read_address", read_address, e.addr);
                end
            end else if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
                miss("read_enable_missing");
                void'(exp_rd.pop_front());
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) miss("rsp_unexpected");
                else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_fwd", rsp_fwd, e.fwd);
                end
            end else if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
                miss("rsp_missing");
                void'(exp_rsp.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [4:0] ra, input logic hold);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; drain_hold = hold;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic hold);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, hold);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i] = 32'h0;
            cm[i]  = 32'h0;
        end
        ram[31] = 32'hA5A5A5A5; cm[31] = 32'hA5A5A5A5;
        ram[30] = 32'h5A5A5A5A; cm[30] = 32'h5A5A5A5A;
        data_out = 32'h0;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; drain_hold = 1'b0;

        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'(i % 2), 5'(i), $urandom, 1'((i + 1) % 2), 5'(i), 1'b0);

        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        idle(4, 1'b0);
        chk("single_write_drained", wb_count, 3'd0);

        drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1);
        idle(4, 1'b1);
        idle(5, 1'b0);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 5'(i), 32'h100 + i, 1'b0, 5'd0, 1'b1);
        chk("full_count", wb_count, 3'd4);
        chk("full_wr_ready", wr_ready, 1'b0);
        drive(1'b0, 1'b1, 5'd4, 32'hBAD, 1'b0, 5'd0, 1'b1);
        chk("full_reject_count", wb_count, 3'd4);
        idle(7, 1'b0);

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 1'b0);
        idle(5, 1'b0);

        drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b0);
        idle(5, 1'b0);

        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        idle(3, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
        idle(5, 1'b0);

        for (int i = 0; i < 800; i++)
            drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
                  1'($urandom_range(0, 3) == 0));
        idle(12, 1'b0);

        chk("pending_writes_left", exp_wr.size(), 0);
        chk("pending_reads_left", exp_rd.size(), 0);
        chk("pending_rsps_left", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
